obuft_bus_sequencer: RTL and testbench



---
 rtl/obuft_seq_pkg.sv | 20 ++
 rtl/obuft_bus_sequencer_if.sv | 28 ++
 rtl/obuft_seq_cnt.sv | 33 +++
 rtl/obuft_bus_sequencer.sv | 117 +++++++++++
 tb/tb_obuft_bus_sequencer.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/obuft_seq_pkg.sv
// Shared types and helpers for the tri-state pad bus sequencer.
package obuft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        TURN   = 2'd3
    } state_e;

    // Width of a counter that must reach max(hold, turn); never narrower than 1 bit.
    function automatic int cnt_width(input int hold, input int turn);
        int m;
        int w;
        m = (hold > turn) ? hold : turn;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/obuft_bus_sequencer_if.sv
// Handshake and pad-side signals of the sequencer, bundled for the port list.
interface obuft_bus_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             wr_valid;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ready;
    logic             rd_req;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic [WIDTH-1:0] pad_o;
    logic [WIDTH-1:0] pad_t;
    logic [WIDTH-1:0] pad_i;
    logic             busy;

    // Sequencer side.
    modport slave (
        input  wr_valid, wr_data, rd_req, pad_i,
        output wr_ready, rd_ready, rd_data, rd_valid, pad_o, pad_t, busy
    );

    // Requester / pad-model side.
    modport master (
        output wr_valid, wr_data, rd_req, pad_i,
        input  wr_ready, rd_ready, rd_data, rd_valid, pad_o, pad_t, busy
    );
endinterface

// File: rtl/obuft_seq_cnt.sv
// Up-counter that loads zero on clr, counts on inc and stops at TERM.
module obuft_seq_cnt #(
    parameter int W    = 1,
    parameter int TERM = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic at_term
);
    localparam logic [W-1:0] TERM_W = W'(TERM);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_term = (cnt_q == TERM_W);

    // Load zero or step; the terminal compare keeps the count from wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && !at_term)
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/obuft_bus_sequencer.sv
// Registered driver for a bank of tri-state pad buffers: turns a write stream
// into pad data/enables, serves single pad reads, and inserts hold and
// turnaround dead cycles so the shared bus is never contended.
module obuft_bus_sequencer
    import obuft_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 1,
    parameter int TURN_CYCLES = 2
) (
    input logic                  CLK,
    input logic                  RST_N,
    obuft_bus_sequencer_if.slave bus
);
    localparam int CW = cnt_width(HOLD_CYCLES, TURN_CYCLES);

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] pad_o_q,    pad_o_d;
    logic             pad_t_q,    pad_t_d;
    logic [WIDTH-1:0] rd_data_q,  rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic wr_ready, rd_ready;
    logic wr_acc, rd_acc;
    logic hold_term, turn_term;

    // Handshake readiness is a pure decode of the state.
    assign wr_ready = (state_q == IDLE) || (state_q == DRIVE);
    assign rd_ready = (state_q == IDLE);
    assign wr_acc   = bus.wr_valid && wr_ready;
    // A pending write always beats a read in the same cycle.
    assign rd_acc   = bus.rd_req && rd_ready && !bus.wr_valid;

    // Hold counter restarts on every accepted word, counts idle DRIVE cycles.
    obuft_seq_cnt #(.W(CW), .TERM(HOLD_CYCLES)) u_hold_cnt (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clr     (wr_acc),
        .inc     (state_q == DRIVE && !wr_acc),
        .at_term (hold_term)
    );

    // Turnaround counter sits at zero outside TURN, so entry always starts at 0.
    obuft_seq_cnt #(.W(CW), .TERM(TURN_CYCLES - 1)) u_turn_cnt (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clr     (state_q != TURN),
        .inc     (state_q == TURN),
        .at_term (turn_term)
    );

    // Next-state and output-register decode.
    always_comb begin
        state_d    = state_q;
        pad_o_d    = pad_o_q;
        pad_t_d    = pad_t_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_acc) begin
                    state_d = DRIVE;
                    pad_o_d = bus.wr_data;
                    pad_t_d = 1'b0;
                end else if (rd_acc) begin
                    state_d = SAMPLE;
                end
            end
            DRIVE: begin
                if (wr_acc) begin
                    pad_o_d = bus.wr_data;
                end else if (hold_term) begin
                    state_d = TURN;
                    pad_t_d = 1'b1;
                end
            end
            SAMPLE: begin
                // pad_i is assumed already synchronous to CLK.
                rd_data_d  = bus.pad_i;
                rd_valid_d = 1'b1;
                state_d    = TURN;
            end
            TURN: begin
                if (turn_term) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                pad_t_d = 1'b1;
            end
        endcase
    end

    // State and output registers; async reset releases the bus immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            pad_o_q    <= '0;
            pad_t_q    <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pad_o_q    <= pad_o_d;
            pad_t_q    <= pad_t_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_ready = rd_ready;
    assign bus.busy     = (state_q != IDLE);
    assign bus.pad_o    = pad_o_q;
    assign bus.pad_t    = {WIDTH{pad_t_q}};
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
endmodule

// File: tb/tb_obuft_bus_sequencer.sv
// Directed bench for the tri-state pad bus sequencer (WIDTH=8, HOLD=1, TURN=2).
module tb_obuft_bus_sequencer;

    logic CLK;
    logic RST_N;
    int   n_cmp;
    int   n_bad;

    obuft_bus_sequencer_if #(.WIDTH(8)) bus ();

    obuft_bus_sequencer #(
        .WIDTH       (8),
        .HOLD_CYCLES (1),
        .TURN_CYCLES (2)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Bus must be released whenever the sequencer is in SAMPLE or TURN
    // (the only busy states that refuse writes).
    always @(negedge CLK) begin
        if (RST_N === 1'b1 && bus.busy === 1'b1 && bus.wr_ready === 1'b0) begin
            n_cmp++;
            if (bus.pad_t !== 8'hFF) begin
                n_bad++;
                $display("FAIL no_drive_in_sample_turn: pad_t=%h required FF", bus.pad_t);
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        bus.wr_valid = 1'b0; bus.wr_data = 8'h00; bus.rd_req = 1'b0; bus.pad_i = 8'h00;
        step; step;
        RST_N = 1'b1;
        step;
        n_cmp++; if (bus.pad_t !== 8'hFF) begin n_bad++; $display("FAIL rst_pad_t: got %h want FF", bus.pad_t); end
        n_cmp++; if (bus.pad_o !== 8'h00) begin n_bad++; $display("FAIL rst_pad_o: got %h want 00", bus.pad_o); end
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_bad++; $display("FAIL rst_wr_ready: got %b want 1", bus.wr_ready); end
        n_cmp++; if (bus.rd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_rd_ready: got %b want 1", bus.rd_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        n_cmp++; if ({bus.rd_valid, bus.rd_data} !== 9'h000) begin n_bad++; $display("FAIL rst_rd: got %b/%h want 0/00", bus.rd_valid, bus.rd_data); end
        // Enter DRIVE, then pull reset between edges.
        bus.wr_valid = 1'b1; bus.wr_data = 8'h5A;
        step;
        bus.wr_valid = 1'b0;
        n_cmp++; if (bus.pad_t !== 8'h00) begin n_bad++; $display("FAIL rst_pre_drive: pad_t=%h want 00", bus.pad_t); end
        #2 RST_N = 1'b0;
        #1;
        n_cmp++; if (bus.pad_t !== 8'hFF) begin n_bad++; $display("FAIL rst_async_release: pad_t=%h want FF", bus.pad_t); end
        n_cmp++; if (bus.pad_o !== 8'h00) begin n_bad++; $display("FAIL rst_async_pad_o: got %h want 00", bus.pad_o); end
        step;
        RST_N = 1'b1;
        step;
    endtask

    task automatic test_single_write;
        bus.wr_valid = 1'b1; bus.wr_data = 8'hA5;
        step;
        bus.wr_valid = 1'b0; bus.wr_data = 8'h00;
        for (int c = 1; c <= 2; c++) begin
            n_cmp++; if (bus.pad_t !== 8'h00 || bus.pad_o !== 8'hA5) begin n_bad++; $display("FAIL single_drive c%0d: pad_t=%h pad_o=%h want 00/A5", c, bus.pad_t, bus.pad_o); end
            n_cmp++; if (bus.wr_ready !== 1'b1 || bus.rd_ready !== 1'b0 || bus.busy !== 1'b1) begin n_bad++; $display("FAIL single_drive_hs c%0d: wr_rdy=%b rd_rdy=%b busy=%b want 1/0/1", c, bus.wr_ready, bus.rd_ready, bus.busy); end
            step;
        end
        for (int c = 3; c <= 4; c++) begin
            n_cmp++; if (bus.pad_t !== 8'hFF || bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL single_turn c%0d: pad_t=%h wr_rdy=%b want FF/0", c, bus.pad_t, bus.wr_ready); end
            step;
        end
        n_cmp++; if (bus.busy !== 1'b0 || bus.wr_ready !== 1'b1 || bus.pad_o !== 8'hA5 || bus.pad_t !== 8'hFF) begin
            n_bad++; $display("FAIL single_idle: busy=%b wr_rdy=%b pad_o=%h pad_t=%h want 0/1/A5/FF", bus.busy, bus.wr_ready, bus.pad_o, bus.pad_t);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] w;
        for (int i = 0; i < 4; i++) begin
            w = 8'(i + 1);
            bus.wr_valid = 1'b1; bus.wr_data = w;
            step;
            n_cmp++; if (bus.pad_o !== w || bus.pad_t !== 8'h00) begin n_bad++; $display("FAIL burst_word %0d: pad_o=%h pad_t=%h want %h/00", i, bus.pad_o, bus.pad_t, w); end
        end
        bus.wr_valid = 1'b0;
        step;
        n_cmp++; if (bus.pad_o !== 8'h04 || bus.pad_t !== 8'h00) begin n_bad++; $display("FAIL burst_hold: pad_o=%h pad_t=%h want 04/00", bus.pad_o, bus.pad_t); end
        step;
        n_cmp++; if (bus.pad_t !== 8'hFF || bus.busy !== 1'b1) begin n_bad++; $display("FAIL burst_turn1: pad_t=%h busy=%b want FF/1", bus.pad_t, bus.busy); end
        step;
        n_cmp++; if (bus.pad_t !== 8'hFF || bus.busy !== 1'b1) begin n_bad++; $display("FAIL burst_turn2: pad_t=%h busy=%b want FF/1", bus.pad_t, bus.busy); end
        step;
        n_cmp++; if (bus.busy !== 1'b0 || bus.pad_o !== 8'h04) begin n_bad++; $display("FAIL burst_idle: busy=%b pad_o=%h want 0/04", bus.busy, bus.pad_o); end
    endtask

    task automatic test_read;
        bus.pad_i = 8'h3C; bus.rd_req = 1'b1;
        step;
        bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.pad_t !== 8'hFF || bus.busy !== 1'b1) begin n_bad++; $display("FAIL read_sample: rd_valid=%b pad_t=%h busy=%b want 0/FF/1", bus.rd_valid, bus.pad_t, bus.busy); end
        step;
        bus.pad_i = 8'hE7;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C) begin n_bad++; $display("FAIL read_data: rd_valid=%b rd_data=%h want 1/3C", bus.rd_valid, bus.rd_data); end
        n_cmp++; if (bus.pad_t !== 8'hFF) begin n_bad++; $display("FAIL read_pad_t: got %h want FF", bus.pad_t); end
        step;
        n_cmp++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h3C) begin n_bad++; $display("FAIL read_pulse_hold: rd_valid=%b rd_data=%h want 0/3C", bus.rd_valid, bus.rd_data); end
        step;
        n_cmp++; if (bus.busy !== 1'b0 || bus.rd_ready !== 1'b1) begin n_bad++; $display("FAIL read_idle: busy=%b rd_rdy=%b want 0/1", bus.busy, bus.rd_ready); end
        bus.pad_i = 8'h00;
    endtask

    task automatic test_write_beats_read;
        int  rise;
        bit  got;
        rise = -1; got = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_data = 8'h77; bus.rd_req = 1'b1; bus.pad_i = 8'hC3;
        step;
        bus.wr_valid = 1'b0;
        n_cmp++; if (bus.pad_o !== 8'h77 || bus.pad_t !== 8'h00) begin n_bad++; $display("FAIL wr_first: pad_o=%h pad_t=%h want 77/00", bus.pad_o, bus.pad_t); end
        for (int k = 2; k <= 20 && !got; k++) begin
            step;
            if (bus.rd_ready === 1'b1) begin got = 1'b1; rise = k; end
        end
        n_cmp++; if (rise !== 5) begin n_bad++; $display("FAIL rd_ready_rise: cycle=%0d want 5", rise); end
        step;
        bus.rd_req = 1'b0;
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL pend_sample: rd_valid=%b want 0", bus.rd_valid); end
        step;
        n_cmp++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hC3) begin n_bad++; $display("FAIL pend_read: rd_valid=%b rd_data=%h want 1/C3", bus.rd_valid, bus.rd_data); end
        step; step;
        bus.pad_i = 8'h00;
    endtask

    task automatic test_write_in_turn;
        bus.wr_valid = 1'b1; bus.wr_data = 8'h11;
        step;
        bus.wr_valid = 1'b0;
        step; step;
        // First TURN cycle: offer a new word.
        bus.wr_valid = 1'b1; bus.wr_data = 8'h22;
        for (int c = 3; c <= 4; c++) begin
            n_cmp++; if (bus.wr_ready !== 1'b0 || bus.pad_o !== 8'h11 || bus.pad_t !== 8'hFF) begin
                n_bad++; $display("FAIL turn_holdoff c%0d: wr_rdy=%b pad_o=%h pad_t=%h want 0/11/FF", c, bus.wr_ready, bus.pad_o, bus.pad_t);
            end
            step;
        end
        n_cmp++; if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL turn_release: wr_rdy=%b busy=%b want 1/0", bus.wr_ready, bus.busy); end
        step;
        bus.wr_valid = 1'b0;
        n_cmp++; if (bus.pad_o !== 8'h22 || bus.pad_t !== 8'h00) begin n_bad++; $display("FAIL turn_accept: pad_o=%h pad_t=%h want 22/00", bus.pad_o, bus.pad_t); end
        for (int c = 0; c < 5; c++) step;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL turn_final_idle: busy=%b want 0", bus.busy); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_single_write;
        test_back_to_back;
        test_read;
        test_write_beats_read;
        test_write_in_turn;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
